// File: rtl/serial_rx_ctrl_pkg.sv
// Shared definitions for the serial packet router: state encoding and default field widths.
// Used by the receive sequencer and by the datapath.
package serial_rx_pkg;

    localparam int PORT_W_DEF = 2;
    localparam int LEN_W_DEF  = 4;

    typedef logic [2:0] state_t;

    // Fixed numeric encoding so existing datapath decode and debug tooling stay valid.
    localparam state_t IDLE = 3'd0;
    localparam state_t PORT = 3'd1;
    localparam state_t LEN  = 3'd2;
    localparam state_t LOAD = 3'd3;
    localparam state_t XMIT = 3'd4;
    localparam state_t DONE = 3'd5;

endpackage

// File: rtl/serial_rx_ctrl_if.sv
// Handshake bundle between the receive sequencer and the router datapath.
// The slave modport is the sequencer's view; master is the datapath/bench side.
interface serial_rx_ctrl_if
    import serial_rx_pkg::*;
    #(parameter int LEN_W = LEN_W_DEF)
    ();

    logic             clk_en;
    logic             serin;
    logic [LEN_W-1:0] num_data;
    logic             port_sh_en;
    logic             len_sh_en;
    logic             serout_en;
    logic             busy;
    logic             done;
    logic [3:0]       pkt_cnt;

    modport master (
        output clk_en, serin, num_data,
        input  port_sh_en, len_sh_en, serout_en, busy, done, pkt_cnt
    );

    modport slave (
        input  clk_en, serin, num_data,
        output port_sh_en, len_sh_en, serout_en, busy, done, pkt_cnt
    );

endinterface

// File: rtl/serial_rx_ctrl_xmit_len_cnt.sv
// Loadable down-counter holding the remaining payload bit count of the current packet.
// Decrement saturates at zero.
module xmit_len_cnt
    import serial_rx_pkg::*;
    #(parameter int LEN_W = LEN_W_DEF)
    (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             dec,
    input  logic [LEN_W-1:0] ld_val,
    output logic             zero
    );

    logic [LEN_W-1:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
        end else if (ld) begin
            rem <= ld_val;
        end else if (dec && (rem != '0)) begin
            rem <= rem - LEN_W'(1);
        end
    end

    assign zero = (rem == '0);

endmodule

// File: rtl/serial_rx_ctrl.sv
// Receive sequencer for the serial packet router: walks start/port/length/payload fields,
// drives the datapath shift enables and demux enable, and counts completed packets.
module serial_rx_ctrl
    import serial_rx_pkg::*;
    #(
    parameter int PORT_W = PORT_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
    )
    (
    input  logic             clk,
    input  logic             rst,
    serial_rx_ctrl_if.slave  bus
    );

    localparam int HDR_MAX = (PORT_W > LEN_W) ? PORT_W : LEN_W;
    localparam int HDR_W   = $clog2(HDR_MAX) + 1;

    state_t           state;
    logic [HDR_W-1:0] hdr_cnt;
    logic [3:0]       pkt_cnt_r;
    logic             rem_ld;
    logic             rem_dec;
    logic             rem_zero;
    logic [LEN_W-1:0] rem_ld_val;

    // rem is preloaded with length-1 so the zero flag marks the last payload bit.
    always_comb begin
        rem_ld     = (state == LOAD) && (bus.num_data != '0);
        rem_ld_val = bus.num_data - LEN_W'(1);
        rem_dec    = (state == XMIT) && bus.clk_en && !rem_zero;
    end

    xmit_len_cnt #(.LEN_W(LEN_W)) u_rem (
        .clk    (clk),
        .rst    (rst),
        .ld     (rem_ld),
        .dec    (rem_dec),
        .ld_val (rem_ld_val),
        .zero   (rem_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hdr_cnt   <= '0;
            pkt_cnt_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clk_en && !bus.serin) begin
                        state   <= PORT;
                        hdr_cnt <= '0;
                    end
                end
                PORT: begin
                    if (bus.clk_en) begin
                        if (hdr_cnt == HDR_W'(PORT_W - 1)) begin
                            state   <= LEN;
                            hdr_cnt <= '0;
                        end else begin
                            hdr_cnt <= hdr_cnt + HDR_W'(1);
                        end
                    end
                end
                LEN: begin
                    if (bus.clk_en) begin
                        hdr_cnt <= hdr_cnt + HDR_W'(1);
                        if (hdr_cnt == HDR_W'(LEN_W - 1)) begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    state <= (bus.num_data == '0) ? DONE : XMIT;
                end
                XMIT: begin
                    if (bus.clk_en && rem_zero) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    pkt_cnt_r <= pkt_cnt_r + 4'd1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.port_sh_en = (state == PORT) && bus.clk_en;
        bus.len_sh_en  = (state == LEN)  && bus.clk_en;
        bus.serout_en  = (state == XMIT) && bus.clk_en;
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.pkt_cnt    = pkt_cnt_r;
    end

endmodule
